program_sequencer: RTL and testbench
====================================

# program_sequencer

Fetch/decode/sequence controller for `computational_unit`. It holds the 8-bit program counter and reads one 8-bit instruction per fetch from an asynchronous-read program memory. It decodes each instruction into the datapath control word (`nibble_ir`, `source_sel`, `reg_en`, `i_sel`, `x_sel`, `y_sel`) and resolves unconditional and conditional jumps using `r_eq_0` fed back from the datapath. Every instruction takes two cycles: FETCH, then EXEC.

## Interface
- No parameters. Widths are fixed by the datapath.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `sync_reset`  in  1  asynchronous, active-high reset. The name is kept for port compatibility with the datapath, which receives the same net.
- `pm_data`  in  8  instruction byte at `pm_addr`, valid combinationally in the same cycle.
- `r_eq_0`  in  1  zero flag of the datapath result register.
- `pm_addr`  out  8  program counter.
- `nibble_ir`  out  4  `ir[3:0]`, immediate data and ALU function to the datapath.
- `source_sel`  out  4  data-bus source select.
- `reg_en`  out  9  register write enables, one-hot or zero. Bit mapping: 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 dm write, 8 o_reg.
- `i_sel`, `x_sel`, `y_sel`  out  1  datapath mux controls.

## Operation
- Registers: `pc[7:0]`, `ir[7:0]`, and `state` in {FETCH, EXEC}.
- Reset (asynchronous) sets `pc`=0x00, `ir`=0x00 and `state`=FETCH.
- FETCH:
  - All outputs idle: `reg_en`=0, `source_sel`=0xA (zero), `i_sel`=`x_sel`=`y_sel`=0.
  - At the edge: `ir`←`pm_data`, `pc`←`pc`+1 (8-bit wrap, 0xFF→0x00), `state`←EXEC.
- EXEC: decode `ir` combinationally and drive the control word. At the edge, `state`←FETCH; jumps may load `pc`.
- Destination code `d[2:0]` → `reg_en` bit: 0→0, 1→1, 2→2, 3→3, 4→8 (o_reg), 5→5, 6→6, 7→7 (dm).
- LOAD, `ir[7]`=0:
  - Destination `d`=`ir[6:4]`; `source_sel`=8 (pm_data).
  - The datapath receives `ir[3:0]` via `nibble_ir`.
- MOVE, `ir[7:6]`=10, with `d`=`ir[5:3]` and `s`=`ir[2:0]`:
  - Normal case: `source_sel`={0,`s`}.
  - `d`==`s` and `d`≠6: `source_sel`=9 (i_pins).
  - `d`==`s`==6: `i_sel`=1 (i←m+i), `source_sel`=0xA.
  - `i_sel`=0 in every other case.
- ALU, `ir[7:5]`=110:
  - `reg_en`=bit 4 only; `x_sel`=`ir[4]`, `y_sel`=`ir[3]`.
  - `nibble_ir[2:0]` carries the ALU function; `source_sel`=0xA.
- JMP, `ir[7:4]`=1110: `reg_en`=0; `pc`←{`ir[3:0]`,4'h0}.
- JNZ, `ir[7:4]`=1111: `reg_en`=0; if `r_eq_0`==0 then `pc`←{`ir[3:0]`,4'h0}, else `pc` is unchanged (already incremented).
- `nibble_ir`=`ir[3:0]` in all states.

## Timing
- First FETCH is the first rising edge after `sync_reset` deasserts, with `pm_addr`=0x00.
- Two cycles per instruction. Datapath registers commit at the EXEC→FETCH edge.
- A jump target appears on `pm_addr` in the FETCH cycle that immediately follows the jump's EXEC. There is no delay slot.
- JNZ samples `r_eq_0` during its own EXEC cycle. That value reflects the last ALU EXEC commit; an ALU instruction directly preceding JNZ is visible to it.
- `reg_en` is asserted for exactly one cycle per writing instruction and never in FETCH.
- Reset asserted mid-EXEC: `reg_en` drops to 0 immediately (asynchronous) and the state returns to FETCH at `pc`=0x00. No partial write is attempted; the datapath is reset on the same net.
- `pc` wraps silently. Execution continues from 0x00 after the instruction at 0xFF.
- JMP to its own 16-byte page base is the halt idiom, e.g. 0xE0 placed at 0x00.

## Test plan
- Reset held for 3 cycles, then released:
  - during reset: `pm_addr`=0x00, `reg_en`=0, `source_sel`=0xA;
  - first EXEC decodes `pm_data` from address 0x00.
- LOAD 0x23 at 0x00:
  - EXEC cycle: `reg_en`=9'h004, `source_sel`=8, `nibble_ir`=3;
  - next FETCH: `pm_addr`=0x01.
- MOVE 0x8C (d=1, s=4): `source_sel`=4, `reg_en`=9'h002.
- MOVE special cases:
  - 0x89 (d=s=1): `source_sel`=9, `reg_en`=9'h002;
  - 0xB6 (d=s=6): `reg_en`=9'h040, `i_sel`=1.
- ALU 0xDA: `reg_en`=9'h010, `x_sel`=1, `y_sel`=1, `nibble_ir`=0xA.
- JNZ 0xF3 at 0x10:
  - with `r_eq_0`=0: next `pm_addr`=0x30;
  - with `r_eq_0`=1: next `pm_addr`=0x11.
- Wrap-around: non-jump instruction at 0xFF → next `pm_addr`=0x00.
- Reset mid-EXEC: assert reset during EXEC of 0x23 → `reg_en` drops to 0 in the same cycle.

Source files
------------

// File: rtl/program_sequencer.sv
// Two-cycle FETCH/EXEC sequencer: holds the PC, latches one instruction per fetch and
// decodes it into the computational_unit control word, resolving JMP/JNZ locally.
module program_sequencer (
   input  logic       clk,
   input  logic       sync_reset,
   input  logic [7:0] pm_data,
   input  logic       r_eq_0,
   output logic [7:0] pm_addr,
   output logic [3:0] nibble_ir,
   output logic [3:0] source_sel,
   output logic [8:0] reg_en,
   output logic       i_sel,
   output logic       x_sel,
   output logic       y_sel
);

   typedef enum logic {FETCH, EXEC} state_t;

   state_t     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] ir_q, ir_d;

   logic [2:0] mv_dst, mv_src;

   // Destination code 4 selects o_reg (bit 8); bit 4 is reserved for ALU writes to r.
   function automatic logic [8:0] dest_en(input logic [2:0] d);
      logic [8:0] en;
      if (d == 3'd4) en = 9'h100;
      else           en = 9'h001 << d;
      return en;
   endfunction

   assign mv_dst = ir_q[5:3];
   assign mv_src = ir_q[2:0];

   always_comb begin
      pc_d       = pc_q;
      ir_d       = ir_q;
      state_d    = state_q;
      reg_en     = '0;
      source_sel = 4'hA;
      i_sel      = 1'b0;
      x_sel      = 1'b0;
      y_sel      = 1'b0;
      case (state_q)
         FETCH: begin
            ir_d    = pm_data;
            pc_d    = pc_q + 8'd1;
            state_d = EXEC;
         end
         EXEC: begin
            state_d = FETCH;
            if (!ir_q[7]) begin
               reg_en     = dest_en(ir_q[6:4]);
               source_sel = 4'h8;
            end else if (ir_q[7:6] == 2'b10) begin
               reg_en = dest_en(mv_dst);
               if (mv_dst != mv_src)    source_sel = {1'b0, mv_src};
               else if (mv_dst != 3'd6) source_sel = 4'h9;
               else                     i_sel      = 1'b1;
            end else if (ir_q[7:5] == 3'b110) begin
               reg_en = 9'h010;
               x_sel  = ir_q[4];
               y_sel  = ir_q[3];
            end else if (!ir_q[4] || !r_eq_0) begin
               // JMP always taken; JNZ taken only when r is non-zero, else pc already advanced.
               pc_d = {ir_q[3:0], 4'h0};
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge sync_reset) begin
      if (sync_reset) begin
         state_q <= FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   assign pm_addr   = pc_q;
   assign nibble_ir = ir_q[3:0];

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: a small program in a behavioural memory,
// with hand-derived control words checked on the falling edge of each cycle.
module tb_program_sequencer;

   logic       clk = 1'b0;
   logic       sync_reset;
   logic [7:0] pm_data;
   logic       r_eq_0;
   logic [7:0] pm_addr;
   logic [3:0] nibble_ir;
   logic [3:0] source_sel;
   logic [8:0] reg_en;
   logic       i_sel, x_sel, y_sel;

   logic [7:0] mem [256];

   int unsigned checks = 0;
   int unsigned passes = 0;

   program_sequencer dut (
      .clk        (clk),
      .sync_reset (sync_reset),
      .pm_data    (pm_data),
      .r_eq_0     (r_eq_0),
      .pm_addr    (pm_addr),
      .nibble_ir  (nibble_ir),
      .source_sel (source_sel),
      .reg_en     (reg_en),
      .i_sel      (i_sel),
      .x_sel      (x_sel),
      .y_sel      (y_sel)
   );

   always #5 clk = ~clk;

   assign pm_data = mem[pm_addr];

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) passes++;
      else $error("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'h23;
      mem[8'h01] = 8'h8C;
      mem[8'h02] = 8'h89;
      mem[8'h03] = 8'hB6;
      mem[8'h04] = 8'hDA;
      mem[8'h05] = 8'hE1;
      mem[8'h10] = 8'hF3;
      mem[8'h11] = 8'hEF;
      mem[8'h30] = 8'hE1;
      mem[8'hF0] = 8'h7F;
      mem[8'hFF] = 8'h45;

      sync_reset = 1'b1;
      r_eq_0     = 1'b0;
      repeat (3) @(posedge clk);
      cyc();
      chk("rst_addr", 16'(pm_addr), 16'h00);
      chk("rst_reg_en", 16'(reg_en), 16'h000);
      chk("rst_src", 16'(source_sel), 16'hA);
      sync_reset = 1'b0;

      cyc();
      chk("load_reg_en", 16'(reg_en), 16'h004);
      chk("load_src", 16'(source_sel), 16'h8);
      chk("load_nib", 16'(nibble_ir), 16'h3);
      cyc();
      chk("fetch1_addr", 16'(pm_addr), 16'h01);
      chk("fetch1_reg_en", 16'(reg_en), 16'h000);
      chk("fetch1_src", 16'(source_sel), 16'hA);

      cyc();
      chk("mov8c_src", 16'(source_sel), 16'h4);
      chk("mov8c_reg_en", 16'(reg_en), 16'h002);
      chk("mov8c_isel", 16'(i_sel), 16'h0);
      cyc();

      cyc();
      chk("mov89_src", 16'(source_sel), 16'h9);
      chk("mov89_reg_en", 16'(reg_en), 16'h002);
      cyc();

      cyc();
      chk("movb6_reg_en", 16'(reg_en), 16'h040);
      chk("movb6_isel", 16'(i_sel), 16'h1);
      chk("movb6_src", 16'(source_sel), 16'hA);
      cyc();
      chk("fetch4_isel", 16'(i_sel), 16'h0);

      cyc();
      chk("alu_reg_en", 16'(reg_en), 16'h010);
      chk("alu_xsel", 16'(x_sel), 16'h1);
      chk("alu_ysel", 16'(y_sel), 16'h1);
      chk("alu_nib", 16'(nibble_ir), 16'hA);
      chk("alu_src", 16'(source_sel), 16'hA);
      cyc();

      cyc();
      chk("jmp_reg_en", 16'(reg_en), 16'h000);
      cyc();
      chk("jmp_target", 16'(pm_addr), 16'h10);

      r_eq_0 = 1'b0;
      cyc();
      chk("jnz_reg_en", 16'(reg_en), 16'h000);
      cyc();
      chk("jnz_taken", 16'(pm_addr), 16'h30);

      cyc();
      cyc();
      chk("jmp_back", 16'(pm_addr), 16'h10);
      r_eq_0 = 1'b1;
      cyc();
      cyc();
      chk("jnz_not_taken", 16'(pm_addr), 16'h11);

      cyc();
      cyc();
      chk("jmp_f0", 16'(pm_addr), 16'hF0);
      cyc();
      chk("dm_reg_en", 16'(reg_en), 16'h080);
      chk("dm_nib", 16'(nibble_ir), 16'hF);
      cyc();
      chk("addr_f1", 16'(pm_addr), 16'hF1);
      repeat (28) cyc();
      chk("addr_ff", 16'(pm_addr), 16'hFF);
      cyc();
      chk("oreg_reg_en", 16'(reg_en), 16'h100);
      cyc();
      chk("wrap_addr", 16'(pm_addr), 16'h00);

      cyc();
      chk("pre_rst_reg_en", 16'(reg_en), 16'h004);
      #1 sync_reset = 1'b1;
      #1;
      chk("midrst_reg_en", 16'(reg_en), 16'h000);
      chk("midrst_addr", 16'(pm_addr), 16'h00);
      chk("midrst_src", 16'(source_sel), 16'hA);
      cyc();
      sync_reset = 1'b0;
      cyc();
      chk("post_rst_reg_en", 16'(reg_en), 16'h004);
      cyc();
      chk("post_rst_addr", 16'(pm_addr), 16'h01);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
